hazard_ctrl_mc: RTL

Parametrised hazard/forwarding controller for the five-stage pipeline. It generalises the fixed-width hazard unit with a configurable register-address width and a multi-cycle execute stall sequencer for variable-latency ops such as MUL/DIV. It also adds decode flush and a saturating stall-cycle performance counter. It sits beside the datapath: it consumes stage register IDs and control bits, and drives stall, flush and forward selects.

---
 rtl/hazard_ctrl_mc_if.sv | 34 +++
 rtl/hazard_ctrl_mc.sv | 110 +++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc_if.sv
// Hazard-control signal bundle between the pipeline datapath (master) and hazard_ctrl_mc (slave).
// Register IDs and enables flow in; stall, flush, forward selects and perf count flow out.
interface hazard_ctrl_mc_if #(
  parameter int RA_W   = 5,
  parameter int PERF_W = 16
);
  logic [RA_W-1:0]   RsD, RtD, RsE, RtE;
  logic [RA_W-1:0]   WriteRegE, WriteRegM, WriteRegW;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic              MemtoRegE, MemtoRegM;
  logic              BranchD, JumpD, PCSrcD, McStartE;
  logic              StallF, StallD, StallE;
  logic              FlushD, FlushE, FlushM;
  logic              ForwardAD, ForwardBD;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              McBusy;
  logic [PERF_W-1:0] StallCnt;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, JumpD, PCSrcD, McStartE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAD, ForwardBD, ForwardAE, ForwardBE, McBusy, StallCnt
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, JumpD, PCSrcD, McStartE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAD, ForwardBD, ForwardAE, ForwardBE, McBusy, StallCnt
  );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for the five-stage pipeline with a saturating stall counter.
// Define HAZ_MC_EN to build the multi-cycle execute stall sequencer (MUL/DIV occupancy of E).
module hazard_ctrl_mc #(
  parameter int RA_W   = 5,
  parameter int MC_LAT = 4,
  parameter int PERF_W = 16
) (
  input logic             clk,
  input logic             reset,
  hazard_ctrl_mc_if.slave hz
);

  // Register 0 is hardwired, so a zero ID never creates a dependency.
  function automatic logic regHit(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  logic              lwStall, brStall, mcStall, mcBusy;
  logic              stallF, stallD, stallE, flushE, flushM;
  logic [1:0]        fwdAE, fwdBE;
  logic [PERF_W-1:0] stallCntQ;

  assign lwStall = hz.MemtoRegE && (regHit(hz.RtE, hz.RsD) || regHit(hz.RtE, hz.RtD));

  assign brStall = hz.BranchD &&
                   ((hz.RegWriteE && (regHit(hz.WriteRegE, hz.RsD) || regHit(hz.WriteRegE, hz.RtD))) ||
                    (hz.MemtoRegM && (regHit(hz.WriteRegM, hz.RsD) || regHit(hz.WriteRegM, hz.RtD))));

`ifdef HAZ_MC_EN
  localparam logic [3:0] MC_LOAD  = 4'(MC_LAT - 1);
  localparam bit         MC_MULTI = (MC_LAT > 1);

  logic [3:0] cnt;

  // cnt==1 is the final E cycle: the op advances, so the stall lifts there.
  assign mcStall = hz.McStartE && MC_MULTI && (cnt != 4'd1);
  assign mcBusy  = (cnt != 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if ((cnt == 4'd0) && mcStall) begin
      cnt <= MC_LOAD;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end
`else
  logic unusedMcStart;
  assign unusedMcStart = hz.McStartE;
  assign mcStall       = 1'b0;
  assign mcBusy        = 1'b0;
`endif

  // A held multi-cycle op freezes E, so load/branch bubbles are not inserted behind it.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    if (mcStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (lwStall || brStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  always_comb begin
    fwdAE = 2'b00;
    fwdBE = 2'b00;
    if (hz.RegWriteM && regHit(hz.WriteRegM, hz.RsE)) begin
      fwdAE = 2'b10;
    end else if (hz.RegWriteW && regHit(hz.WriteRegW, hz.RsE)) begin
      fwdAE = 2'b01;
    end
    if (hz.RegWriteM && regHit(hz.WriteRegM, hz.RtE)) begin
      fwdBE = 2'b10;
    end else if (hz.RegWriteW && regHit(hz.WriteRegW, hz.RtE)) begin
      fwdBE = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCntQ <= '0;
    end else if (stallF && (stallCntQ != '1)) begin
      stallCntQ <= stallCntQ + PERF_W'(1);
    end
  end

  assign hz.StallF    = stallF;
  assign hz.StallD    = stallD;
  assign hz.StallE    = stallE;
  assign hz.FlushD    = (hz.PCSrcD || hz.JumpD) && !stallD;
  assign hz.FlushE    = flushE;
  assign hz.FlushM    = flushM;
  assign hz.ForwardAD = hz.RegWriteM && regHit(hz.WriteRegM, hz.RsD);
  assign hz.ForwardBD = hz.RegWriteM && regHit(hz.WriteRegM, hz.RtD);
  assign hz.ForwardAE = fwdAE;
  assign hz.ForwardBE = fwdBE;
  assign hz.McBusy    = mcBusy;
  assign hz.StallCnt  = stallCntQ;

endmodule
